// File: rtl/pong_input_pkg.sv
// rtl/pong_input_pkg.sv - shared encodings for the button event arbiter
// Purpose: event type and channel FSM state encodings, event type width,
//          and a small constant helper used for counter sizing.
// Ports:   none (package).
package pong_input_pkg;

  localparam int EVT_TYPE_W = 2;

  typedef enum logic [EVT_TYPE_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_HOLD    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - serialised button event stream
// Purpose: valid/ready event port carrying one button event per handshake.
// Signals: evt_valid (event held), evt_id (button index), evt_type (event
//          kind), evt_ready (consumer accepts the current event).
// Modports: master = arbiter side, slave = game logic side.
interface button_event_arbiter_if #(
  parameter int BUTTONS = 4
);
  import pong_input_pkg::*;

  logic                         evt_valid;
  logic                         evt_ready;
  logic [$clog2(BUTTONS)-1:0]   evt_id;
  logic [EVT_TYPE_W-1:0]        evt_type;

  modport master (output evt_valid, output evt_id, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_type, output evt_ready);
endinterface

// File: rtl/button_event_fsm.sv
// rtl/button_event_fsm.sv - one button channel: event FSM, tick counter, pending slot
// Purpose: turns one debounced level into PRESS/RELEASE/HOLD/REPEAT events
//          and parks the latest event in a single pending slot.
// Ports:   clk, rst (async active-low), level (debounced level),
//          tick (shared ms strobe), grant (arbiter takes the slot this cycle),
//          pend_valid/pend_type (slot contents), drop (an un-granted valid
//          slot is being overwritten this cycle).
module button_event_fsm
  import pong_input_pkg::*;
#(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int REPEAT_EN    = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      level,
  input  logic      tick,
  input  logic      grant,
  output logic      pend_valid,
  output evt_type_e pend_type,
  output logic      drop
);

  localparam int CW = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          emit;
  evt_type_e     emit_type;
  logic          pend_valid_q;
  evt_type_e     pend_type_q;

  // Release is tested before tick so a same-cycle release suppresses HOLD/REPEAT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_type = EVT_PRESS;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (level) begin
          emit      = 1'b1;
          emit_type = EVT_PRESS;
          state_d   = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!level) begin
          emit      = 1'b1;
          emit_type = EVT_RELEASE;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            emit      = 1'b1;
            emit_type = EVT_HOLD;
            state_d   = ST_HELD;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HELD: begin
        if (!level) begin
          emit      = 1'b1;
          emit_type = EVT_RELEASE;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (tick) begin
          if (REPEAT_EN != 0 && cnt_q == REPEAT_LAST) begin
            emit      = 1'b1;
            emit_type = EVT_REPEAT;
            cnt_d     = '0;
          end else if (REPEAT_EN != 0 || cnt_q != CNT_MAX) begin
            // Without repeats the counter just saturates while held.
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_type_q  <= EVT_PRESS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // A new event always wins the slot; a grant in the same cycle means the
      // old event already left, so that case is not a drop.
      if (emit) begin
        pend_valid_q <= 1'b1;
        pend_type_q  <= emit_type;
      end else if (grant) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign drop       = emit && pend_valid_q && !grant;
  assign pend_valid = pend_valid_q;
  assign pend_type  = pend_type_q;

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - button levels to a round-robin serialised event stream
// Purpose: shared ms prescaler, one event FSM per button, round-robin
//          arbiter into a single output event register, sticky drop flag.
// Ports:   clk, rst (async active-low), btn_level (debounced levels,
//          1 = pressed), drop_clr (clears drop_flag), drop_flag (sticky,
//          a pending event was overwritten), evt (master side of the
//          valid/ready event port: evt_valid, evt_id, evt_type, evt_ready).
module button_event_arbiter
  import pong_input_pkg::*;
#(
  parameter int BUTTONS      = 4,
  parameter int TICK_DIV     = 50_000,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int REPEAT_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUTTONS-1:0]    btn_level,
  input  logic                  drop_clr,
  output logic                  drop_flag,
  button_event_arbiter_if.master evt
);

  localparam int IDW = $clog2(BUTTONS);
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]         presc_q;
  logic                  tick;
  logic [BUTTONS-1:0]    pend_valid;
  evt_type_e             pend_type [BUTTONS];
  logic [BUTTONS-1:0]    drop_vec;
  logic [BUTTONS-1:0]    grant;
  logic                  load_en;
  logic                  gnt_found;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        rr_q;
  logic                  evt_valid_q;
  logic [IDW-1:0]        evt_id_q;
  logic [EVT_TYPE_W-1:0] evt_type_q;
  logic                  drop_flag_q;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  for (genvar g = 0; g < BUTTONS; g++) begin : g_chan
    button_event_fsm #(
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .level     (btn_level[g]),
      .tick      (tick),
      .grant     (grant[g]),
      .pend_valid(pend_valid[g]),
      .pend_type (pend_type[g]),
      .drop      (drop_vec[g])
    );
  end

  // The output register may take a new event when empty or being consumed.
  assign load_en = !evt_valid_q || evt.evt_ready;

  // First pending slot at or after rr_q, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      if (!gnt_found && pend_valid[(int'(rr_q) + i) % BUTTONS]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(rr_q) + i) % BUTTONS);
      end
    end
    if (load_en && gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= '0;
      drop_flag_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (load_en) begin
        if (gnt_found) begin
          evt_valid_q <= 1'b1;
          evt_id_q    <= gnt_idx;
          evt_type_q  <= pend_type[gnt_idx];
          rr_q        <= (gnt_idx == IDW'(BUTTONS - 1)) ? '0 : gnt_idx + IDW'(1);
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (|drop_vec) begin
        drop_flag_q <= 1'b1;
      end else if (drop_clr) begin
        drop_flag_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;
  assign evt.evt_type  = evt_type_q;
  assign drop_flag     = drop_flag_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - randomized and directed bench with a reference model
module tb_button_event_arbiter;

  localparam int B  = 4;
  localparam int TD = 4;
  localparam int H  = 3;
  localparam int R  = 2;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       ready;
  logic       drop_clr;
  logic       drop0, drop1;

  button_event_arbiter_if #(.BUTTONS(B)) evt0 ();
  button_event_arbiter_if #(.BUTTONS(B)) evt1 ();
  assign evt0.evt_ready = ready;
  assign evt1.evt_ready = ready;

  button_event_arbiter #(.BUTTONS(B), .TICK_DIV(TD), .HOLD_TICKS(H),
                         .REPEAT_TICKS(R), .REPEAT_EN(1)) dut0 (
    .clk(clk), .rst(rst), .btn_level(btn), .drop_clr(drop_clr),
    .drop_flag(drop0), .evt(evt0));

  button_event_arbiter #(.BUTTONS(B), .TICK_DIV(TD), .HOLD_TICKS(H),
                         .REPEAT_TICKS(R), .REPEAT_EN(0)) dut1 (
    .clk(clk), .rst(rst), .btn_level(btn), .drop_clr(drop_clr),
    .drop_flag(drop1), .evt(evt1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per button "ticks since press" plus one-deep slots,
  // and a queue-free round-robin output register. Index 0 = repeats on.
  int rep_en [2] = '{1, 0};
  int presc;
  int pressed [2][B];
  int ht      [2][B];
  int slot_v  [2][B];
  int slot_t  [2][B];
  int m_ov [2], m_oid [2], m_ot [2], m_rr [2], m_drop [2];

  task automatic model_reset();
    presc = 0;
    for (int n = 0; n < 2; n++) begin
      m_ov[n] = 0; m_oid[n] = 0; m_ot[n] = 0; m_rr[n] = 0; m_drop[n] = 0;
      for (int b = 0; b < B; b++) begin
        pressed[n][b] = 0; ht[n][b] = 0; slot_v[n][b] = 0; slot_t[n][b] = 0;
      end
    end
  endtask

  task automatic model_step();
    int tick, load, g, oldt, ev, dropped, j;
    if (!rst) begin
      model_reset();
      return;
    end
    tick  = (presc == TD - 1) ? 1 : 0;
    presc = (presc + 1) % TD;
    for (int n = 0; n < 2; n++) begin
      load = (!m_ov[n] || ready) ? 1 : 0;
      g = -1;
      oldt = 0;
      if (load) begin
        for (int i = 0; i < B; i++) begin
          j = (m_rr[n] + i) % B;
          if (g < 0 && slot_v[n][j] != 0) begin
            g = j;
            oldt = slot_t[n][j];
          end
        end
      end
      dropped = 0;
      for (int b = 0; b < B; b++) begin
        ev = -1;
        if (!pressed[n][b] && btn[b]) begin
          ev = 0; pressed[n][b] = 1; ht[n][b] = 0;
        end else if (pressed[n][b] && !btn[b]) begin
          ev = 1; pressed[n][b] = 0;
        end else if (pressed[n][b] && tick) begin
          ht[n][b]++;
          if (ht[n][b] == H) ev = 2;
          else if (rep_en[n] != 0 && ht[n][b] > H && (ht[n][b] - H) % R == 0) ev = 3;
        end
        if (ev >= 0) begin
          if (slot_v[n][b] != 0 && b != g) dropped = 1;
          slot_v[n][b] = 1;
          slot_t[n][b] = ev;
        end else if (b == g) begin
          slot_v[n][b] = 0;
        end
      end
      if (load) begin
        if (g >= 0) begin
          m_ov[n] = 1; m_oid[n] = g; m_ot[n] = oldt; m_rr[n] = (g + 1) % B;
        end else begin
          m_ov[n] = 0;
        end
      end
      if (dropped) m_drop[n] = 1;
      else if (drop_clr) m_drop[n] = 0;
    end
  endtask

  task automatic cmp(input int n, input logic v, input logic [1:0] id,
                     input logic [1:0] ty, input logic df);
    check($sformatf("i%0d evt_valid", n), v, m_ov[n]);
    if (m_ov[n] != 0) begin
      check($sformatf("i%0d evt_id", n), id, m_oid[n]);
      check($sformatf("i%0d evt_type", n), ty, m_ot[n]);
    end
    check($sformatf("i%0d drop_flag", n), df, m_drop[n]);
  endtask

  // Inputs change on the falling edge; model and DUT both sample at the rising edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp(0, evt0.evt_valid, evt0.evt_id, evt0.evt_type, drop0);
    cmp(1, evt1.evt_valid, evt1.evt_id, evt1.evt_type, drop1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int found;

  initial begin
    rst = 1'b0; btn = 4'h0; ready = 1'b1; drop_clr = 1'b0;
    model_reset();
    @(negedge clk);

    // Held in reset with all buttons toggling.
    for (int i = 0; i < 6; i++) begin
      btn = 4'($urandom_range(0, 15)) | ((i % 2 == 0) ? 4'hF : 4'h0);
      step();
    end
    btn = 4'hF;
    rst = 1'b1;
    run(8);

    // Release all, then single button hold / repeat.
    btn = 4'h0;
    run(10);
    btn = 4'h1;
    run(45);
    btn = 4'h0;
    run(6);

    // Simultaneous presses.
    btn = 4'hA;
    run(6);
    btn = 4'h0;
    run(6);
    btn = 4'hF;
    run(6);
    btn = 4'h0;
    run(8);

    // Backpressure with overwrite of button 1.
    btn = 4'h1;
    run(2);
    ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5)  btn = 4'h3;
      if (i == 10) btn = 4'h1;
      step();
    end
    check("stall_drop_set", drop0, 1);
    ready = 1'b1;
    run(8);
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    check("drop_cleared", drop0, 0);
    btn = 4'h0;
    run(8);

    // Release on the cycle the HOLD of button 2 is being granted.
    btn = 4'h4;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step();
      if (slot_v[0][2] != 0 && slot_t[0][2] == 2) found = 1;
    end
    check("hold_pending_seen", found, 1);
    btn = 4'h0;
    run(5);
    check("grant_new_no_drop", drop0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < B; b++)
        if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
      ready    = ($urandom_range(0, 3) != 0);
      drop_clr = ($urandom_range(0, 31) == 0);
      step();
    end

    // Asynchronous reset while held with an event in the output register.
    ready = 1'b1; drop_clr = 1'b0; btn = 4'h0;
    run(8);
    btn = 4'h1;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (pressed[0][0] != 0 && ht[0][0] >= H && m_ov[0] != 0) found = 1;
    end
    check("held_valid_seen", found, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", evt0.evt_valid, 0);
    check("async_rst_id", evt0.evt_id, 0);
    check("async_rst_type", evt0.evt_type, 0);
    check("async_rst_drop", drop0, 0);
    model_reset();
    @(negedge clk);
    run(3);
    rst = 1'b1;
    run(2);
    check("fresh_press_valid", evt0.evt_valid, 1);
    check("fresh_press_type", evt0.evt_type, 0);
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
